// File: rtl/imm_pipe.sv
// imm_pipe: buffered RV32I immediate generator.
//
// Decodes the instruction format from the opcode, builds the sign-extended
// immediate and pc + imm, and queues {imm, fmt, target} in a DEPTH-entry FIFO.
//
// Ports:
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake (in_ready = !full)
//   in_instr, in_pc       instruction word and its PC
//   out_valid/out_ready   output handshake (out_valid = FIFO not empty)
//   out_imm/out_fmt       head entry immediate and format code
//   out_target            head entry pc + imm
//   illegal_cnt           saturating count of accepted illegal opcodes
//
// Handshake: a word transfers on a rising edge where valid && ready are both
// high. Valid never waits on ready; ready does not depend on valid. While
// out_valid is high and out_ready is low the head entry, and so every out_*
// value, holds still. A full FIFO keeps in_ready low even in a pop cycle, so
// in_ready only rises the cycle after a pop.
module imm_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic [CNTW-1:0] illegal_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    // ------------------------------------------------------------------
    // Input-side decode (combinational)
    // ------------------------------------------------------------------
    logic [2:0]      d_fmt;
    logic [31:0]     d_imm32;
    logic [XLEN-1:0] d_imm;
    logic [XLEN-1:0] d_target;
    logic            s;

    assign s = in_instr[31];

    always_comb begin
        d_fmt   = FMT_ILL;
        d_imm32 = '0;
        unique case (in_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                d_fmt   = FMT_I;
                d_imm32 = {{20{s}}, in_instr[31:20]};
            end
            7'b0100011: begin
                d_fmt   = FMT_S;
                d_imm32 = {{20{s}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                d_fmt   = FMT_B;
                d_imm32 = {{19{s}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                d_fmt   = FMT_U;
                d_imm32 = {in_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                d_fmt   = FMT_J;
                d_imm32 = {{11{s}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            end
            7'b0110011: begin
                d_fmt   = FMT_R;
                d_imm32 = '0;
            end
            default: begin
                d_fmt   = FMT_ILL;
                d_imm32 = '0;
            end
        endcase
    end

    // bit 31 of d_imm32 is instr[31] (or 0 for R/illegal), so a signed
    // widening cast finishes the extension to XLEN.
    assign d_imm    = XLEN'($signed(d_imm32));
    assign d_target = in_pc + d_imm;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [XLEN-1:0] imm_mem [DEPTH];
    logic [2:0]      fmt_mem [DEPTH];
    logic [XLEN-1:0] tgt_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            full;
    logic            push;
    logic            pop;

    assign full      = (count == FULL_CNT);
    assign in_ready  = !full;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                imm_mem[i] <= '0;
                fmt_mem[i] <= '0;
                tgt_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                imm_mem[wr_ptr] <= d_imm;
                fmt_mem[wr_ptr] <= d_fmt;
                tgt_mem[wr_ptr] <= d_target;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign out_imm    = imm_mem[rd_ptr];
    assign out_fmt    = fmt_mem[rd_ptr];
    assign out_target = tgt_mem[rd_ptr];

    // ------------------------------------------------------------------
    // Illegal-opcode counter, saturating at all-ones
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_cnt <= '0;
        end else if (push && (d_fmt == FMT_ILL) && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_pipe.sv
module tb_imm_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- main DUT: XLEN=32, DEPTH=2, CNTW=16 ----------------
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic [31:0] out_target;
  logic [15:0] illegal_cnt;

  imm_pipe #(.XLEN(32), .DEPTH(2), .CNTW(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_target(out_target), .illegal_cnt(illegal_cnt)
  );

  // ---------------- XLEN=64 DUT ----------------
  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [31:0] w_in_instr = '0;
  logic [63:0] w_in_pc = '0;
  logic        w_out_valid;
  logic [63:0] w_out_imm;
  logic [2:0]  w_out_fmt;
  logic [63:0] w_out_target;
  logic [15:0] w_illegal_cnt;

  imm_pipe #(.XLEN(64), .DEPTH(2), .CNTW(16)) dut64 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_instr(w_in_instr), .in_pc(w_in_pc),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_imm(w_out_imm),
    .out_fmt(w_out_fmt), .out_target(w_out_target), .illegal_cnt(w_illegal_cnt)
  );

  // ---------------- CNTW=2 DUT ----------------
  logic        c_in_valid = 1'b0;
  logic        c_in_ready;
  logic        c_out_valid;
  logic [31:0] c_out_imm;
  logic [2:0]  c_out_fmt;
  logic [31:0] c_out_target;
  logic [1:0]  c_illegal_cnt;

  imm_pipe #(.XLEN(32), .DEPTH(2), .CNTW(2)) dutc (
    .clk(clk), .reset_n(reset_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_instr(32'h0000_007F), .in_pc(32'h0),
    .out_valid(c_out_valid), .out_ready(1'b1), .out_imm(c_out_imm),
    .out_fmt(c_out_fmt), .out_target(c_out_target), .illegal_cnt(c_illegal_cnt)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // entry = {fmt[2:0], imm[31:0], target[31:0]}
  logic [66:0] exp_q[$];
  logic [66:0] mon_e;
  int exp_cnt = 0;

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 64'(out_imm), 64'hDEAD);
      end else begin
        mon_e = exp_q.pop_front();
        check("pop_fmt", 64'(out_fmt), 64'(mon_e[66:64]));
        check("pop_imm", 64'(out_imm), 64'(mon_e[63:32]));
        check("pop_target", 64'(out_target), 64'(mon_e[31:0]));
      end
    end
  end

  // reference decode, written from the ISA field layout with arithmetic shifts
  function automatic logic [34:0] model(input logic [31:0] i);
    logic signed [31:0] t;
    logic [2:0]  f;
    logic [31:0] m;
    f = 3'd7;
    m = '0;
    case (i[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: begin f = 3'd1; t = $signed(i) >>> 20; m = t; end
      7'h23: begin f = 3'd2; t = $signed(i) >>> 20; m = {t[31:5], i[11:7]}; end
      7'h63: begin f = 3'd3; t = $signed(i) >>> 19; m = {t[31:12], i[7], i[30:25], i[11:8], 1'b0}; end
      7'h37, 7'h17: begin f = 3'd4; m = {i[31:12], 12'b0}; end
      7'h6F: begin f = 3'd5; t = $signed(i) >>> 11; m = {t[31:20], i[19:12], i[20], i[30:21], 1'b0}; end
      7'h33: begin f = 3'd0; m = '0; end
      default: begin f = 3'd7; m = '0; end
    endcase
    return {f, m};
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [2:0] fmt, input logic [31:0] imm);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc = pc;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
    end else begin
      exp_q.push_back({fmt, imm, pc + imm});
      if (fmt == 3'd7) exp_cnt++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [31:0] instr, input logic [31:0] pc);
    logic [34:0] r;
    r = model(instr);
    send(instr, pc, r[34:32], r[31:0]);
  endtask

  task automatic drain(input string tag);
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  logic [6:0] opc_tab [10] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                               7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
  bit rand_done = 1'b0;

  initial begin
    // ---------- reset state ----------
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_imm", 64'(out_imm), 64'd0);
    check("rst_out_fmt", 64'(out_fmt), 64'd0);
    check("rst_out_target", 64'(out_target), 64'd0);
    check("rst_illegal_cnt", 64'(illegal_cnt), 64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // ---------- XLEN=64 ----------
    w_in_valid = 1'b1; w_in_instr = 32'hFFF0_0093; w_in_pc = 64'h100;
    @(negedge clk);
    check("x64_in_ready", 64'(w_in_ready), 64'd1);
    @(posedge clk);
    #1 w_in_instr = 32'hFE11_2E23; w_in_pc = 64'h104;
    @(negedge clk);
    check("x64_addi_valid", 64'(w_out_valid), 64'd1);
    check("x64_addi_fmt", 64'(w_out_fmt), 64'd1);
    check("x64_addi_imm", w_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("x64_addi_target", w_out_target, 64'hFF);
    @(posedge clk);
    #1 w_in_valid = 1'b0;
    @(negedge clk);
    check("x64_sw_fmt", 64'(w_out_fmt), 64'd2);
    check("x64_sw_imm", w_out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    check("x64_sw_target", w_out_target, 64'h100);

    // ---------- CNTW=2 saturation ----------
    @(posedge clk);
    #1 c_in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("c2_cnt_at_3", 64'(c_illegal_cnt), 64'd3);
    repeat (2) @(posedge clk);
    #1 c_in_valid = 1'b0;
    @(negedge clk);
    check("c2_cnt_saturated", 64'(c_illegal_cnt), 64'd3);
    check("c2_fmt_illegal", 64'(c_out_fmt), 64'd7);
    @(posedge clk);
    #1;

    // ---------- directed immediate forms, XLEN=32 ----------
    out_ready = 1'b1;
    send(32'hFFF0_0093, 32'h0000_0100, 3'd1, 32'hFFFF_FFFF); // addi x1,x0,-1
    send(32'hFE11_2E23, 32'h0000_0104, 3'd2, 32'hFFFF_FFFC); // sw x1,-4(x2)
    send(32'h1234_52B7, 32'h0000_0108, 3'd4, 32'h1234_5000); // lui
    send(32'h1234_5297, 32'h0000_1000, 3'd4, 32'h1234_5000); // auipc -> 0x12346000
    send(32'h0010_00EF, 32'h0000_2000, 3'd5, 32'h0000_0800); // jal x1,+2048
    send(32'hFE00_0CE3, 32'h0000_3000, 3'd3, 32'hFFFF_FFF8); // beq x0,x0,-8
    send(32'h0020_81B3, 32'h0000_4000, 3'd0, 32'h0000_0000); // add (R)
    send(32'hFFFF_FFF0, 32'hFFFF_FFF8, 3'd7, 32'h0000_0000); // illegal, pc unchanged
    drain("drain_directed");
    check("cnt_after_directed", 64'(illegal_cnt), 64'(exp_cnt));

    // ---------- illegal x3 ----------
    repeat (3) send(32'h0000_007F, 32'h0000_0200, 3'd7, 32'h0);
    drain("drain_illegal");
    check("cnt_illegal_3", 64'(illegal_cnt), 64'(exp_cnt));
    check("cnt_illegal_abs", 64'(illegal_cnt), 64'd4);

    // ---------- backpressure, DEPTH=2 ----------
    out_ready = 1'b0;
    send(32'hFFF0_0093, 32'h0000_0400, 3'd1, 32'hFFFF_FFFF);
    send(32'h1234_52B7, 32'h0000_0404, 3'd4, 32'h1234_5000);
    in_valid = 1'b1; in_instr = 32'h0000_007F; in_pc = 32'h0000_0408;
    repeat (2) begin
      @(negedge clk);
      check("full_in_ready", 64'(in_ready), 64'd0);
      check("full_head_stable", 64'(out_imm), 64'hFFFF_FFFF);
      check("blocked_no_count", 64'(illegal_cnt), 64'(exp_cnt));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("full_pop_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("after_pop_in_ready", 64'(in_ready), 64'd1);
    exp_q.push_back({3'd7, 32'h0, 32'h0000_0408});
    exp_cnt++;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("third_at_head", 64'(out_valid), 64'd1);
    drain("drain_backpressure");
    check("cnt_after_bp", 64'(illegal_cnt), 64'(exp_cnt));

    // ---------- random stream with random backpressure ----------
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          logic [31:0] w;
          w = $urandom();
          w[6:0] = opc_tab[$urandom_range(0, 9)];
          send_model(w, $urandom());
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain("drain_random");
    check("cnt_after_random", 64'(illegal_cnt), 64'(exp_cnt));

    // ---------- reset with words queued ----------
    out_ready = 1'b0;
    send(32'h0000_007F, 32'h0000_0500, 3'd7, 32'h0);
    send(32'hFFF0_0093, 32'h0000_0504, 3'd1, 32'hFFFF_FFFF);
    check("pre_reset_full", 64'(in_ready), 64'd0);
    #3 reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_cnt", 64'(illegal_cnt), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_out_imm", 64'(out_imm), 64'd0);
    exp_q.delete();
    exp_cnt = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_no_pop", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
